// File: rtl/bomb_timer_ctrl_pkg.sv
// Shared definitions for the bomb-defuse countdown controller: state encodings,
// the gameState width, and small saturation/clamp helpers.
package bomb_timer_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_RUN   = 3'd3,
    S_BOOM  = 3'd4,
    S_SAFE  = 3'd5
  } state_t;

  // Strike counter increments but never wraps past 3.
  function automatic logic [1:0] strike_inc(input logic [1:0] s);
    return (s == 2'd3) ? 2'd3 : s + 2'd1;
  endfunction

  // The divider cannot produce a sensible tick below a period of 2.
  function automatic logic [31:0] clamp_period(input logic [31:0] p);
    return (p < 32'd2) ? 32'd2 : p;
  endfunction

endpackage

// File: rtl/bomb_timer_ctrl_tick_prescaler.sv
// Countdown tick divider. Counts 0..period-1 while enabled and flags the last
// count as the tick. The period is sampled only while cleared or on a wrap, so
// a period change takes effect at the next wrap.
module tick_prescaler
  import bomb_timer_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] per_q, per_d;
  logic        wrap;

  assign wrap = enable && (cnt_q == per_q - 32'd1);
  assign tick = wrap;

  // Next count and period: clear and wrap both restart at 0 and resample the period.
  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (clear || wrap) begin
      cnt_d = 32'd0;
      per_d = clamp_period(period);
    end else if (enable) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 32'd0;
      per_q <= 32'd2;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/bomb_timer_ctrl.sv
// Bomb-defuse game sequencer: two-cycle digit reconfig, countdown tick
// generation and outcome tracking (timeout, strikes, defuse).
// Optional build macro STRIKE_SPEEDUP_EN: each strike halves the tick period
// (clamped to 2), applied at the next prescaler wrap.
module bomb_timer_ctrl
  import bomb_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int STRIKE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               armReq,
  input  logic               defuseReq,
  input  logic               wrongReq,
  input  logic               timerZero,
  output logic               reconfigOut,
  output logic               tickOut,
  output logic [STATE_W-1:0] gameState,
  output logic               exploded,
  output logic               defused,
  output logic [1:0]         strikeCount
);

  localparam logic [31:0] TICK_DIV_U = 32'(TICK_DIV);
  localparam logic [1:0]  LIMIT      = 2'(STRIKE_LIMIT);

  state_t      state_q;
  logic [1:0]  strike_q;
  logic [1:0]  strike_nx;
  logic        reconf_q;
  logic        expl_q;
  logic        def_q;
  logic        run;
  logic        presc_tick;
  logic [31:0] period;

  assign run       = (state_q == S_RUN);
  assign strike_nx = strike_inc(strike_q);

`ifdef STRIKE_SPEEDUP_EN
  assign period = TICK_DIV_U >> strike_q;
`else
  assign period = TICK_DIV_U;
`endif

  // Prescaler is held at 0 outside RUN so every round starts a fresh period.
  tick_prescaler u_presc (
    .clk    (clk),
    .rst    (rst),
    .clear  (!run),
    .enable (run),
    .period (period),
    .tick   (presc_tick)
  );

  // Tick is dropped on the cycle a timeout or an effective defuse wins.
  assign tickOut = presc_tick && !timerZero && !(defuseReq && !wrongReq);

  // Game FSM with registered reconfig/outcome outputs and strike counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      strike_q <= 2'd0;
      reconf_q <= 1'b0;
      expl_q   <= 1'b0;
      def_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (armReq) begin
            state_q  <= S_LOAD1;
            reconf_q <= 1'b1;
            strike_q <= 2'd0;
          end
        end
        S_LOAD1: begin
          state_q  <= S_LOAD2;
          reconf_q <= 1'b1;
        end
        S_LOAD2: begin
          state_q  <= S_RUN;
          reconf_q <= 1'b0;
        end
        S_RUN: begin
          if (timerZero) begin
            state_q <= S_BOOM;
            expl_q  <= 1'b1;
          end else if (wrongReq) begin
            strike_q <= strike_nx;
            if (strike_nx == LIMIT) begin
              state_q <= S_BOOM;
              expl_q  <= 1'b1;
            end
          end else if (defuseReq) begin
            state_q <= S_SAFE;
            def_q   <= 1'b1;
          end
        end
        S_BOOM, S_SAFE: begin
          if (armReq) begin
            state_q  <= S_LOAD1;
            reconf_q <= 1'b1;
            strike_q <= 2'd0;
            expl_q   <= 1'b0;
            def_q    <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          reconf_q <= 1'b0;
          expl_q   <= 1'b0;
          def_q    <= 1'b0;
        end
      endcase
    end
  end

  assign reconfigOut = reconf_q;
  assign gameState   = state_q;
  assign exploded    = expl_q;
  assign defused     = def_q;
  assign strikeCount = strike_q;

endmodule

// File: tb/tb_bomb_timer_ctrl.sv
// Testbench for bomb_timer_ctrl: vector table for the arm/tick/timeout path,
// hand sequences for strikes, defuse, re-arm, async reset and speedup, then
// random stimulus against a behavioural game model.
module tb_bomb_timer_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int STRIKE_LIMIT = 3;
`ifdef STRIKE_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       armReq = 1'b0, defuseReq = 1'b0, wrongReq = 1'b0, timerZero = 1'b0;
  logic       reconfigOut, tickOut, exploded, defused;
  logic [2:0] gameState;
  logic [1:0] strikeCount;

  int n_cmp = 0;
  int n_bad = 0;

  bomb_timer_ctrl #(.TICK_DIV(TICK_DIV), .STRIKE_LIMIT(STRIKE_LIMIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .armReq      (armReq),
    .defuseReq   (defuseReq),
    .wrongReq    (wrongReq),
    .timerZero   (timerZero),
    .reconfigOut (reconfigOut),
    .tickOut     (tickOut),
    .gameState   (gameState),
    .exploded    (exploded),
    .defused     (defused),
    .strikeCount (strikeCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural game model ----------------
  // mode uses the numeric game states; phase is the position inside the
  // current tick period, period the length of that period.
  int m_mode, m_strikes, m_phase, m_period;

  function automatic int eff_period(input int s);
    int p;
    p = SPEEDUP ? (TICK_DIV >> s) : TICK_DIV;
    if (p < 2) p = 2;
    return p;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_strikes = 0; m_phase = 0; m_period = TICK_DIV;
  endtask

  function automatic bit model_tick(input bit d, input bit w, input bit z);
    return (m_mode == 3) && (m_phase == m_period - 1) && !z && !(d && !w);
  endfunction

  task automatic model_step(input bit a, input bit d, input bit w, input bit z);
    case (m_mode)
      0: if (a) begin m_mode = 1; m_strikes = 0; end
      1: m_mode = 2;
      2: begin m_mode = 3; m_phase = 0; m_period = eff_period(m_strikes); end
      3: begin
        if (m_phase == m_period - 1) begin
          m_phase = 0;
          m_period = eff_period(m_strikes);
        end else begin
          m_phase++;
        end
        if (z) m_mode = 4;
        else if (w) begin
          if (m_strikes < 3) m_strikes++;
          if (m_strikes == STRIKE_LIMIT) m_mode = 4;
        end else if (d) m_mode = 5;
      end
      default: if (a) begin m_mode = 1; m_strikes = 0; end
    endcase
  endtask

  task automatic check_model(input bit d, input bit w, input bit z);
    chk("state",    int'(gameState),   m_mode);
    chk("reconfig", int'(reconfigOut), int'(m_mode == 1 || m_mode == 2));
    chk("tick",     int'(tickOut),     int'(model_tick(d, w, z)));
    chk("strikes",  int'(strikeCount), m_strikes);
    chk("exploded", int'(exploded),    int'(m_mode == 4));
    chk("defused",  int'(defused),     int'(m_mode == 5));
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+3, advance model.
  task automatic cyc(input bit a, input bit d, input bit w, input bit z);
    armReq = a; defuseReq = d; wrongReq = w; timerZero = z;
    #2;
    check_model(d, w, z);
    @(posedge clk);
    model_step(a, d, w, z);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_state"},  int'(gameState),   0);
    chk({nm, "_reconf"}, int'(reconfigOut), 0);
    chk({nm, "_tick"},   int'(tickOut),     0);
    chk({nm, "_strike"}, int'(strikeCount), 0);
    chk({nm, "_expl"},   int'(exploded),    0);
    chk({nm, "_def"},    int'(defused),     0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic a, d, w, z;
    int   st;
    logic rc, tk;
    int   sc;
    logic ex, df;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic a, d, w, z, input int st,
                              input logic rc, tk, input int sc, input logic ex, df);
    vec_t v;
    v.a = a; v.d = d; v.w = w; v.z = z; v.st = st;
    v.rc = rc; v.tk = tk; v.sc = sc; v.ex = ex; v.df = df;
    return v;
  endfunction

  initial begin
    // Arm with timerZero low, tick at RUN cycles 4, 8, 12 (ages 3, 7, 11),
    // then timeout on a tick-due cycle, then ignored inputs in BOOM.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
    for (int age = 0; age < 15; age++)
      tbl.push_back(mk(0, 0, 0, 0, 3, 0, logic'(age % 4 == 3), 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4, 0, 0, 0, 1, 0));

    // Reset state
    #2;
    chk_all_zero("rst_a");
    @(posedge clk); #1;
    chk_all_zero("rst_b");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    model_reset();

    // Table-driven arm / tick / timeout
    for (int i = 0; i < tbl.size(); i++) begin
      armReq = tbl[i].a; defuseReq = tbl[i].d; wrongReq = tbl[i].w; timerZero = tbl[i].z;
      #2;
      chk($sformatf("t%0d_state", i),  int'(gameState),   tbl[i].st);
      chk($sformatf("t%0d_reconf", i), int'(reconfigOut), int'(tbl[i].rc));
      chk($sformatf("t%0d_tick", i),   int'(tickOut),     int'(tbl[i].tk));
      chk($sformatf("t%0d_strike", i), int'(strikeCount), tbl[i].sc);
      chk($sformatf("t%0d_expl", i),   int'(exploded),    int'(tbl[i].ex));
      chk($sformatf("t%0d_def", i),    int'(defused),     int'(tbl[i].df));
      @(posedge clk);
      model_step(tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].z);
      #1;
    end

    // Three strikes; the second arrives together with defuse
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("strike1", int'(strikeCount), 1);
    cyc(0, 1, 1, 0);
    chk("strike2", int'(strikeCount), 2);
    chk("wr_def_defused", int'(defused), 0);
    chk("wr_def_state", int'(gameState), 3);
    cyc(0, 0, 1, 0);
    chk("strike3_expl", int'(exploded), 1);
    chk("strike3_cnt", int'(strikeCount), 3);

    // Defuse on a tick-due cycle, then re-arm clears strikes
    cyc(1, 0, 0, 0);
    chk("rearm_strike", int'(strikeCount), 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("defuse_def", int'(defused), 1);
    chk("defuse_expl", int'(exploded), 0);
    cyc(1, 0, 0, 0);
    chk("safe_arm_strike", int'(strikeCount), 0);
    chk("safe_arm_rc1", int'(reconfigOut), 1);
    cyc(0, 0, 0, 0);
    chk("safe_arm_rc2", int'(reconfigOut), 1);
    cyc(0, 0, 0, 0);
    chk("safe_arm_rc3", int'(reconfigOut), 0);
    chk("safe_arm_run", int'(gameState), 3);

    // Async reset between edges while a tick is being issued
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    armReq = 0; defuseReq = 0; wrongReq = 0; timerZero = 0;
    #2;
    chk("pre_rst_tick", int'(tickOut), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk_all_zero("held_rst");
    #3 rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    cyc(1, 0, 0, 0);
    chk("post_rst_load1", int'(gameState), 1);
    chk("post_rst_rc", int'(reconfigOut), 1);
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

    if (SPEEDUP) begin
      // From RUN entry: strike at age 1 -> spacing 2 after the wrap at age 3;
      // a second strike at age 10 keeps spacing at 2.
      for (int age = 0; age < 14; age++) begin
        armReq = 0; defuseReq = 0; timerZero = 0;
        wrongReq = (age == 1 || age == 10);
        #2;
        chk($sformatf("speed_tick_age%0d", age), int'(tickOut),
            int'(age == 3 || age == 5 || age == 7 || age == 9 || age == 11 || age == 13));
        @(posedge clk);
        model_step(1'b0, 1'b0, wrongReq, 1'b0);
        #1;
      end
    end

    // Randomized stimulus against the model
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
